// File: rtl/bsram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bsram_ctrl_pkg
// Shared constants and types for the BSRAM arbiter slice.
//   ADDR_W / DATA_W / DEPTH : default geometry of the 32Kx8 BSRAM
//   state_t                 : controller phase (post-reset clear, normal service)
//   port_t                  : requester identity carried with each read response
// ---------------------------------------------------------------------------
package bsram_ctrl_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way combinational grant with a round-robin pointer or fixed priority.
//   clk, reset : clock, synchronous active-high reset (pointer returns to A)
//   req[1:0]   : bit 0 = port A, bit 1 = port B
//   mode       : 0 = round-robin, 1 = fixed priority A over B
//   gnt[1:0]   : one-hot grant, or zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       mode,
    output logic [1:0] gnt
);
    import bsram_ctrl_pkg::*;

    port_t r_ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (mode || (r_ptr == PORT_A)) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer always hands the next contest to the port that did not just win.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= PORT_A;
        end else if (gnt[0]) begin
            r_ptr <= PORT_B;
        end else if (gnt[1]) begin
            r_ptr <= PORT_A;
        end
    end

endmodule

// File: rtl/bsram_arbiter.sv
// ---------------------------------------------------------------------------
// bsram_arbiter
// Shares one single-port BSRAM between port A (CPU) and port B (loader/debug).
// After reset it can zero-fill the array, then grants one access per cycle and
// routes read data back to the issuing port two cycles after the ack.
//   clk, reset                 : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  : port A request, held stable until a_ack
//   a_ack                      : port A access issued to the BSRAM this cycle
//   a_rvalid/a_rdata           : port A read response (rdata held between responses)
//   b_*                        : same set for port B
//   init_busy                  : high while the post-reset clear runs
//   mem_ce/oce/wre/reset/ad/din: BSRAM control and data pins
//   mem_dout                   : BSRAM read data, valid the cycle after issue
// ---------------------------------------------------------------------------
module bsram_arbiter #(
    parameter int                ADDR_W         = bsram_ctrl_pkg::ADDR_W,
    parameter int                DATA_W         = bsram_ctrl_pkg::DATA_W,
    parameter int                ARB_MODE       = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              init_busy,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic              mem_reset,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    import bsram_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic              FIXED_PRIO = (ARB_MODE != 0);
    localparam logic              DO_CLEAR   = (CLEAR_ON_RESET != 0);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_serve;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_rd_issue;
    logic              r_vld_p1;
    port_t             r_port_p1;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    // Requests are invisible while clearing or in reset, so they simply stay pending.
    assign w_serve = (r_state == ST_SERVE) && !reset;
    assign w_req   = w_serve ? {b_req, a_req} : 2'b00;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .mode  (FIXED_PRIO),
        .gnt   (w_gnt)
    );

    assign a_ack      = w_gnt[0];
    assign b_ack      = w_gnt[1];
    assign w_rd_issue = (w_gnt[0] && !a_we) || (w_gnt[1] && !b_we);

    // During reset the registered state may be anything, so busy is derived
    // directly from the clear setting for that cycle.
    assign init_busy = reset ? DO_CLEAR : (r_state == ST_CLEAR);
    assign mem_oce   = 1'b1;
    assign mem_reset = reset;

    always_comb begin
        mem_ce  = 1'b0;
        mem_wre = 1'b0;
        mem_ad  = '0;
        mem_din = '0;
        if (reset) begin
            mem_ce = 1'b0;
        end else if (r_state == ST_CLEAR) begin
            mem_ce  = 1'b1;
            mem_wre = 1'b1;
            mem_ad  = r_clr_cnt;
            mem_din = CLEAR_VALUE;
        end else if (w_gnt[0]) begin
            mem_ce  = 1'b1;
            mem_wre = a_we;
            mem_ad  = a_addr;
            mem_din = a_wdata;
        end else if (w_gnt[1]) begin
            mem_ce  = 1'b1;
            mem_wre = b_we;
            mem_ad  = b_addr;
            mem_din = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= DO_CLEAR ? ST_CLEAR : ST_SERVE;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST_ADDR) begin
                r_state <= ST_SERVE;
            end
        end
    end

    // ---- stage p1: tag of the read issued last cycle, BSRAM dout valid now ----
    // ---- stage p2: dout captured into the owning port's response registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            r_port_p1  <= PORT_A;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_vld_p1   <= w_rd_issue;
            r_port_p1  <= w_gnt[1] ? PORT_B : PORT_A;
            r_a_rvalid <= r_vld_p1 && (r_port_p1 == PORT_A);
            r_b_rvalid <= r_vld_p1 && (r_port_p1 == PORT_B);
            if (r_vld_p1 && (r_port_p1 == PORT_A)) begin
                r_a_rdata <= mem_dout;
            end
            if (r_vld_p1 && (r_port_p1 == PORT_B)) begin
                r_b_rdata <= mem_dout;
            end
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_bsram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bsram_arbiter
// Two instances share one clock: dut0 (round-robin, clear on reset) and
// dut1 (fixed priority, no clear). Each has its own behavioural BSRAM.
// ---------------------------------------------------------------------------
module tb_bsram_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut0 signals ----------------
    logic        rst0;
    logic        a_req0, a_we0, b_req0, b_we0;
    logic [14:0] a_addr0, b_addr0;
    logic [7:0]  a_wdata0, b_wdata0;
    logic        a_ack0, a_rvalid0, b_ack0, b_rvalid0;
    logic [7:0]  a_rdata0, b_rdata0;
    logic        init_busy0, mem_ce0, mem_oce0, mem_wre0, mem_reset0;
    logic [14:0] mem_ad0;
    logic [7:0]  mem_din0, mem_dout0;

    // ---------------- dut1 signals ----------------
    logic        rst1;
    logic        a_req1, a_we1, b_req1, b_we1;
    logic [14:0] a_addr1, b_addr1;
    logic [7:0]  a_wdata1, b_wdata1;
    logic        a_ack1, a_rvalid1, b_ack1, b_rvalid1;
    logic [7:0]  a_rdata1, b_rdata1;
    logic        init_busy1, mem_ce1, mem_oce1, mem_wre1, mem_reset1;
    logic [14:0] mem_ad1;
    logic [7:0]  mem_din1, mem_dout1;

    bsram_arbiter #(.ADDR_W(15), .DATA_W(8), .ARB_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)) dut0 (
        .clk(clk), .reset(rst0),
        .a_req(a_req0), .a_we(a_we0), .a_addr(a_addr0), .a_wdata(a_wdata0),
        .a_ack(a_ack0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
        .b_req(b_req0), .b_we(b_we0), .b_addr(b_addr0), .b_wdata(b_wdata0),
        .b_ack(b_ack0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
        .init_busy(init_busy0), .mem_ce(mem_ce0), .mem_oce(mem_oce0), .mem_wre(mem_wre0),
        .mem_reset(mem_reset0), .mem_ad(mem_ad0), .mem_din(mem_din0), .mem_dout(mem_dout0)
    );

    bsram_arbiter #(.ADDR_W(15), .DATA_W(8), .ARB_MODE(1), .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h00)) dut1 (
        .clk(clk), .reset(rst1),
        .a_req(a_req1), .a_we(a_we1), .a_addr(a_addr1), .a_wdata(a_wdata1),
        .a_ack(a_ack1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req1), .b_we(b_we1), .b_addr(b_addr1), .b_wdata(b_wdata1),
        .b_ack(b_ack1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .init_busy(init_busy1), .mem_ce(mem_ce1), .mem_oce(mem_oce1), .mem_wre(mem_wre1),
        .mem_reset(mem_reset1), .mem_ad(mem_ad1), .mem_din(mem_din1), .mem_dout(mem_dout1)
    );

    // Behavioural single-port BSRAMs, prefilled with a non-zero pattern so the clear is visible.
    logic [7:0] mem0 [0:32767] = '{default: 8'hEE};
    logic [7:0] mem1 [0:32767] = '{default: 8'hEE};

    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_wre0) mem0[mem_ad0] <= mem_din0;
            else          mem_dout0     <= mem0[mem_ad0];
        end
    end

    always @(posedge clk) begin
        if (mem_ce1) begin
            if (mem_wre1) mem1[mem_ad1] <= mem_din1;
            else          mem_dout1     <= mem1[mem_ad1];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct packed {
        logic a_req, a_we, b_req, b_we;
        logic ea, eb, ewre;
    } vec_t;

    typedef struct {
        int         due;
        logic       port_b;
        logic [7:0] data;
    } rsp_t;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [8];
        rsp_t       q [$];
        logic [7:0] ref_mem [0:63];
        logic       ptr_b, a_pend, b_pend, exp_a, exp_b, exp_ra, exp_rb;
        logic [7:0] last_a, last_b;
        int         bad;

        rst0 = 1'b1; rst1 = 1'b1;
        a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
        b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
        a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0;
        b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;

        // ---------------- reset state ----------------
        tick();
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 15'h7FFF;
        #1;
        chk("rst_a_ack", a_ack0, 0);
        chk("rst_mem_ce", mem_ce0, 0);
        chk("rst_mem_ad", mem_ad0, 0);
        chk("rst_init_busy0", init_busy0, 1);
        chk("rst_init_busy1", init_busy1, 0);
        chk("rst_mem_reset", mem_reset0, 1);
        chk("rst_a_rvalid", a_rvalid0, 0);
        chk("rst_a_rdata", a_rdata0, 0);
        chk("mem_oce", mem_oce0, 1);

        tick();
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        chk("mem_reset_low", mem_reset0, 0);

        // ---------------- reset mid-clear at 0x0100 ----------------
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_ad0 !== 15'(i) || mem_wre0 !== 1'b1 || a_ack0 !== 1'b0) bad++;
            tick(); #1;
        end
        chk("clear_prefix_bad_cycles", bad, 0);
        chk("mid_clear_ad", mem_ad0, 15'h0100);
        rst0 = 1'b1;
        #1;
        chk("midclr_rst_ce", mem_ce0, 0);
        chk("midclr_rst_busy", init_busy0, 1);
        tick();
        rst0 = 1'b0;
        #1;
        chk("clear_restart_ad", mem_ad0, 0);

        // ---------------- full clear with a_req held ----------------
        bad = 0;
        for (int i = 0; i < 32768; i++) begin
            if (init_busy0 !== 1'b1 || mem_wre0 !== 1'b1 || mem_ce0 !== 1'b1 ||
                mem_ad0 !== 15'(i) || mem_din0 !== 8'h00 || a_ack0 !== 1'b0) bad++;
            tick(); #1;
        end
        chk("clear_bad_cycles", bad, 0);
        chk("serve_busy_low", init_busy0, 0);
        chk("serve_first_ack", a_ack0, 1);
        chk("serve_first_ad", mem_ad0, 15'h7FFF);
        chk("serve_first_wre", mem_wre0, 0);
        tick(); a_req0 = 1'b0; #1;
        chk("clr_rd_rvalid_t1", a_rvalid0, 0);
        tick(); #1;
        chk("clr_rd_rvalid_t2", a_rvalid0, 1);
        chk("clr_rd_rdata", a_rdata0, 8'h00);
        tick(); #1;
        chk("clr_rd_rvalid_t3", a_rvalid0, 0);

        // ---------------- randomized round-robin traffic vs reference ----------------
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        ptr_b = 1'b1;                    // last grant went to A
        a_pend = 1'b0; b_pend = 1'b0;
        last_a = 8'h00; last_b = 8'h00;
        for (int i = 0; i < 303; i++) begin
            tick();
            if (i >= 300) begin
                a_req0 = 1'b0; b_req0 = 1'b0;
            end else begin
                if (a_pend) begin
                    if ($urandom_range(0, 3) == 0) a_req0 = 1'b0;
                end else begin
                    a_req0 = ($urandom_range(0, 2) != 0);
                    a_we0 = 1'($urandom_range(0, 1));
                    a_addr0 = 15'($urandom_range(0, 63));
                    a_wdata0 = 8'($urandom);
                end
                if (b_pend) begin
                    if ($urandom_range(0, 3) == 0) b_req0 = 1'b0;
                end else begin
                    b_req0 = ($urandom_range(0, 2) != 0);
                    b_we0 = 1'($urandom_range(0, 1));
                    b_addr0 = 15'($urandom_range(0, 63));
                    b_wdata0 = 8'($urandom);
                end
            end
            #1;
            exp_a = a_req0 && (!b_req0 || !ptr_b);
            exp_b = b_req0 && (!a_req0 || ptr_b);
            chk("rnd_a_ack", a_ack0, exp_a);
            chk("rnd_b_ack", b_ack0, exp_b);
            chk("rnd_mem_ce", mem_ce0, exp_a | exp_b);
            if (exp_a) begin
                chk("rnd_wre_a", mem_wre0, a_we0);
                chk("rnd_ad_a", mem_ad0, a_addr0);
                if (a_we0) chk("rnd_din_a", mem_din0, a_wdata0);
            end else if (exp_b) begin
                chk("rnd_wre_b", mem_wre0, b_we0);
                chk("rnd_ad_b", mem_ad0, b_addr0);
                if (b_we0) chk("rnd_din_b", mem_din0, b_wdata0);
            end else begin
                chk("rnd_wre_idle", mem_wre0, 0);
            end
            exp_ra = 1'b0; exp_rb = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (q[0].port_b) begin exp_rb = 1'b1; last_b = q[0].data; end
                else             begin exp_ra = 1'b1; last_a = q[0].data; end
                void'(q.pop_front());
            end
            chk("rnd_a_rvalid", a_rvalid0, exp_ra);
            chk("rnd_b_rvalid", b_rvalid0, exp_rb);
            chk("rnd_a_rdata", a_rdata0, last_a);
            chk("rnd_b_rdata", b_rdata0, last_b);
            if (exp_a) begin
                if (a_we0) ref_mem[a_addr0[5:0]] = a_wdata0;
                else       q.push_back('{cyc + 2, 1'b0, ref_mem[a_addr0[5:0]]});
                ptr_b = 1'b1;
            end else if (exp_b) begin
                if (b_we0) ref_mem[b_addr0[5:0]] = b_wdata0;
                else       q.push_back('{cyc + 2, 1'b1, ref_mem[b_addr0[5:0]]});
                ptr_b = 1'b0;
            end
            a_pend = a_req0 && !exp_a;
            b_pend = b_req0 && !exp_b;
        end
        chk("rnd_queue_drained", q.size(), 0);

        // ---------------- A write then read of 0x1234 ----------------
        tick();
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 15'h1234; a_wdata0 = 8'hA5; b_req0 = 1'b0;
        #1;
        chk("wr_ack", a_ack0, 1);
        chk("wr_wre", mem_wre0, 1);
        tick(); a_we0 = 1'b0; #1;
        chk("rd_ack", a_ack0, 1);
        chk("rd_wre", mem_wre0, 0);
        tick(); a_req0 = 1'b0; #1;
        chk("wr_no_rvalid", a_rvalid0, 0);
        tick(); #1;
        chk("rd_rvalid", a_rvalid0, 1);
        chk("rd_rdata", a_rdata0, 8'hA5);
        chk("rd_b_rvalid", b_rvalid0, 0);

        // ---------------- B preload and back-to-back reads across halves ----------------
        tick(); b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 15'h4000; b_wdata0 = 8'h11; #1;
        chk("b_pre1_ack", b_ack0, 1);
        tick(); b_addr0 = 15'h3FFF; b_wdata0 = 8'h22; #1;
        chk("b_pre2_ack", b_ack0, 1);
        tick(); b_we0 = 1'b0; b_addr0 = 15'h4000; #1;
        chk("b_rd1_ack", b_ack0, 1);
        tick(); b_addr0 = 15'h3FFF; #1;
        chk("b_rd2_ack", b_ack0, 1);
        tick(); b_req0 = 1'b0; #1;
        chk("b_rd1_rvalid", b_rvalid0, 1);
        chk("b_rd1_rdata", b_rdata0, 8'h11);
        tick(); #1;
        chk("b_rd2_rvalid", b_rvalid0, 1);
        chk("b_rd2_rdata", b_rdata0, 8'h22);
        tick(); #1;
        chk("b_rd_end_rvalid", b_rvalid0, 0);
        chk("b_rdata_held", b_rdata0, 8'h22);

        // ---------------- round-robin alternation, both holding reads ----------------
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 15'h1234;
                b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 15'h4000;
            end
            if (k == 4) begin
                a_req0 = 1'b0; b_req0 = 1'b0;
            end
            #1;
            if (k < 4) begin
                chk("rr_a_ack", a_ack0, (k % 2) == 0);
                chk("rr_b_ack", b_ack0, (k % 2) == 1);
            end
            chk("rr_a_rvalid", a_rvalid0, (k >= 2) && (k % 2 == 0));
            chk("rr_b_rvalid", b_rvalid0, (k >= 2) && (k % 2 == 1));
            if (k >= 2 && k % 2 == 0) chk("rr_a_rdata", a_rdata0, 8'hA5);
            if (k >= 2 && k % 2 == 1) chk("rr_b_rdata", b_rdata0, 8'h11);
        end

        // ---------------- fixed-priority grant table (dut1) ----------------
        //            aq aw bq bw  ea eb wre
        tbl[0] = 7'b0_0_0_0__0_0_0;
        tbl[1] = 7'b1_0_0_0__1_0_0;
        tbl[2] = 7'b1_1_0_0__1_0_1;
        tbl[3] = 7'b0_0_1_0__0_1_0;
        tbl[4] = 7'b0_0_1_1__0_1_1;
        tbl[5] = 7'b1_0_1_0__1_0_0;
        tbl[6] = 7'b1_0_1_1__1_0_0;
        tbl[7] = 7'b1_1_1_0__1_0_1;
        for (int r = 0; r < 8; r++) begin
            tick();
            a_req1 = tbl[r].a_req; a_we1 = tbl[r].a_we; a_addr1 = 15'(r); a_wdata1 = 8'(r);
            b_req1 = tbl[r].b_req; b_we1 = tbl[r].b_we; b_addr1 = 15'(16'h0100 + r); b_wdata1 = 8'(r + 8);
            #1;
            chk("tbl_a_ack", a_ack1, tbl[r].ea);
            chk("tbl_b_ack", b_ack1, tbl[r].eb);
            chk("tbl_wre", mem_wre1, tbl[r].ewre);
            chk("tbl_ad", mem_ad1, tbl[r].ea ? a_addr1 : (tbl[r].eb ? b_addr1 : 15'h0));
        end

        // ---------------- fixed priority: B waits until A drops ----------------
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 15'h0010;
                b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 15'h0020;
            end
            if (k == 4) a_req1 = 1'b0;
            #1;
            chk("fp_a_ack", a_ack1, k < 4);
            chk("fp_b_ack", b_ack1, k == 4);
        end

        // ---------------- reset during an in-flight read (dut1) ----------------
        tick(); b_req1 = 1'b0; a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 15'h0010; #1;
        chk("inflight_ack", a_ack1, 1);
        tick(); rst1 = 1'b1; #1;
        chk("inflight_rst_ack", a_ack1, 0);
        chk("inflight_rst_ce", mem_ce1, 0);
        tick(); rst1 = 1'b0; a_req1 = 1'b0; #1;
        chk("inflight_rvalid_t2", a_rvalid1, 0);
        chk("inflight_rdata_cleared", a_rdata1, 0);
        tick(); #1;
        chk("inflight_rvalid_t3", a_rvalid1, 0);
        chk("inflight_b_rvalid", b_rvalid1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
